// File: rtl/ula_pkg.sv
// ula_pkg: shared constants for the 8-bit ALU.
//   DATA_W  operand width
//   RES_W   result width (one extra bit for carry / borrow)
//   OP_W    opcode width
//   OP_*    opcode encodings; 4'b1100..4'b1111 are reserved and yield 0
package ula_pkg;
  localparam int DATA_W = 8;
  localparam int RES_W  = 9;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_GT   = 4'b0010;
  localparam logic [OP_W-1:0] OP_LT   = 4'b0011;
  localparam logic [OP_W-1:0] OP_GE   = 4'b0100;
  localparam logic [OP_W-1:0] OP_LE   = 4'b0101;
  localparam logic [OP_W-1:0] OP_EQ   = 4'b0110;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b0111;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1010;
  localparam logic [OP_W-1:0] OP_XNOR = 4'b1011;
endpackage

// File: rtl/ula_core.sv
// ula_core: purely combinational ALU function.
// Ports:
//   i_a       operand A, unsigned
//   i_b       operand B, unsigned
//   i_op      operation select
//   o_result  next result; bit 8 is carry (ADD) or borrow (SUB), else 0
module ula_core
  import ula_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_op,
  output logic [RES_W-1:0]  o_result
);

  logic [RES_W-1:0] w_a_ext;
  logic [RES_W-1:0] w_b_ext;

  assign w_a_ext = {1'b0, i_a};
  assign w_b_ext = {1'b0, i_b};

  always_comb begin
    o_result = '0;
    case (i_op)
      // 9-bit arithmetic: the wrap of the subtraction sets bit 8 exactly when A<B
      OP_ADD:  o_result = w_a_ext + w_b_ext;
      OP_SUB:  o_result = w_a_ext - w_b_ext;
      OP_GT:   o_result = {{(RES_W-1){1'b0}}, (i_a >  i_b)};
      OP_LT:   o_result = {{(RES_W-1){1'b0}}, (i_a <  i_b)};
      OP_GE:   o_result = {{(RES_W-1){1'b0}}, (i_a >= i_b)};
      OP_LE:   o_result = {{(RES_W-1){1'b0}}, (i_a <= i_b)};
      OP_EQ:   o_result = {{(RES_W-1){1'b0}}, (i_a == i_b)};
      OP_NOT:  o_result = {1'b0, ~i_a};
      OP_AND:  o_result = {1'b0, i_a & i_b};
      OP_OR:   o_result = {1'b0, i_a | i_b};
      OP_XOR:  o_result = {1'b0, i_a ^ i_b};
      OP_XNOR: o_result = {1'b0, ~(i_a ^ i_b)};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/ula.sv
// ula: 8-bit, 12-operation ALU with a registered 9-bit result.
// Ports:
//   entradaA8Bits  operand A, unsigned
//   entradaB8Bits  operand B, unsigned
//   opCode         operation select
//   clock          rising-edge clock
//   saida9Bits     registered result, one-cycle latency
//   reset          asynchronous active-high reset; clears the result at once
module ula
  import ula_pkg::*;
(
  input  logic [DATA_W-1:0] entradaA8Bits,
  input  logic [DATA_W-1:0] entradaB8Bits,
  input  logic [OP_W-1:0]   opCode,
  input  logic              clock,
  output logic [RES_W-1:0]  saida9Bits,
  input  logic              reset
);

  logic [RES_W-1:0] w_next;
  logic [RES_W-1:0] r_saida;

  ula_core u_core (
    .i_a      (entradaA8Bits),
    .i_b      (entradaB8Bits),
    .i_op     (opCode),
    .o_result (w_next)
  );

  // Output register: the only state in the design
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_saida <= '0;
    else       r_saida <= w_next;
  end

  assign saida9Bits = r_saida;

endmodule

// File: tb/tb_ula.sv
// tb_ula: directed self-checking bench for the ula ALU.
module tb_ula;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       clock;
  logic       reset;
  logic [8:0] y;

  int n_tests = 0;
  int n_fail  = 0;

  ula dut (
    .entradaA8Bits (a),
    .entradaB8Bits (b),
    .opCode        (op),
    .clock         (clock),
    .saida9Bits    (y),
    .reset         (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [8:0] exp);
    n_tests++;
    assert (y === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, y, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] o,
                      input logic [7:0] va, input logic [7:0] vb,
                      input logic [8:0] exp);
    op = o; a = va; b = vb;
    @(posedge clock); #1;
    chk(tag, exp);
  endtask

  initial begin
    reset = 1'b1; a = 8'd0; b = 8'd0; op = 4'd0;
    #1;
    chk("reset_state", 9'd0);
    @(negedge clock); reset = 1'b0;

    // arithmetic
    step("add_9_20",     4'b0000, 8'd9,   8'd20,  9'd29);
    step("add_255_255",  4'b0000, 8'd255, 8'd255, 9'h1FE);
    step("sub_25_5",     4'b0001, 8'd25,  8'd5,   9'd20);
    step("sub_255_255",  4'b0001, 8'd255, 8'd255, 9'd0);
    step("sub_5_25",     4'b0001, 8'd5,   8'd25,  9'h1EC);
    step("sub_0_1",      4'b0001, 8'd0,   8'd1,   9'h1FF);

    // comparisons
    step("gt_80_70",     4'b0010, 8'd80,  8'd70,  9'd1);
    step("gt_100_120",   4'b0010, 8'd100, 8'd120, 9'd0);
    step("gt_eq",        4'b0010, 8'd7,   8'd7,   9'd0);
    step("lt_150_220",   4'b0011, 8'd150, 8'd220, 9'd1);
    step("lt_189_110",   4'b0011, 8'd189, 8'd110, 9'd0);
    step("lt_eq",        4'b0011, 8'd7,   8'd7,   9'd0);
    step("ge_2_2",       4'b0100, 8'd2,   8'd2,   9'd1);
    step("ge_45_30",     4'b0100, 8'd45,  8'd30,  9'd1);
    step("ge_90_150",    4'b0100, 8'd90,  8'd150, 9'd0);
    step("le_30_30",     4'b0101, 8'd30,  8'd30,  9'd1);
    step("le_60_120",    4'b0101, 8'd60,  8'd120, 9'd1);
    step("le_200_100",   4'b0101, 8'd200, 8'd100, 9'd0);
    step("eq_50_50",     4'b0110, 8'd50,  8'd50,  9'd1);
    step("eq_100_24",    4'b0110, 8'd100, 8'd24,  9'd0);

    // logic (expected bit 8 is 0 in every case)
    step("not_ff",       4'b0111, 8'hFF, 8'h12, 9'h000);
    step("not_55",       4'b0111, 8'h55, 8'hFF, 9'h0AA);
    step("not_3c",       4'b0111, 8'h3C, 8'h00, 9'h0C3);
    step("and_aa_55",    4'b1000, 8'hAA, 8'h55, 9'h000);
    step("and_aa_aa",    4'b1000, 8'hAA, 8'hAA, 9'h0AA);
    step("or_aa_55",     4'b1001, 8'hAA, 8'h55, 9'h0FF);
    step("or_00_00",     4'b1001, 8'h00, 8'h00, 9'h000);
    step("xor_aa_55",    4'b1010, 8'hAA, 8'h55, 9'h0FF);
    step("xor_ff_ff",    4'b1010, 8'hFF, 8'hFF, 9'h000);
    step("xnor_aa_55",   4'b1011, 8'hAA, 8'h55, 9'h000);
    step("xnor_00_00",   4'b1011, 8'h00, 8'h00, 9'h0FF);

    // reserved opcodes
    for (int k = 12; k < 16; k++) begin
      step($sformatf("reserved_%0d", k), 4'(k), 8'hFF, 8'hFF, 9'd0);
    end

    // latency: inputs changed between edges must not reach the output early
    step("lat_setup", 4'b1010, 8'hAA, 8'h55, 9'h0FF);
    op = 4'b0000; a = 8'd100; b = 8'd200;
    #2;
    chk("lat_hold", 9'h0FF);
    @(posedge clock); #1;
    chk("lat_update", 9'd300);

    // asynchronous reset with ADD 9+20 pending
    op = 4'b0000; a = 8'd9; b = 8'd20;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", 9'd0);
    @(posedge clock); #1;
    chk("rst_hold", 9'd0);
    @(negedge clock); reset = 1'b0;
    #1;
    chk("rst_release_noedge", 9'd0);
    @(posedge clock); #1;
    chk("rst_resume", 9'd29);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
